// File: rtl/mlp_pkg.sv
// Shared constants and state encoding for the MLP output stage.
package mlp_pkg;

    localparam int NUM_OUT = 10;
    localparam int DATA_W  = 16;
    localparam int ADDR_W  = 12;
    localparam int IDX_W   = 4;
    localparam logic [ADDR_W-1:0] OUT_BASE_ADDR = 12'hC00;

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } argmax_state_t;

endpackage

// File: rtl/output_argmax_if.sv
// Final-layer write port and classification result bus for output_argmax.
// wr_en is a one-cycle strobe with no back-pressure; done is a level; finished is a one-cycle result-valid pulse.
interface output_argmax_if;
    import mlp_pkg::*;

    logic                wr_en;
    logic [ADDR_W-1:0]   wr_addr;
    logic [DATA_W-1:0]   wr_data;
    logic                done;
    logic                busy;
    logic                finished;
    logic [IDX_W-1:0]    class_idx;
    logic [DATA_W-1:0]   max_value;
    logic                missing;
    argmax_state_t       dbg_state;

    modport master (
        output wr_en, wr_addr, wr_data, done,
        input  busy, finished, class_idx, max_value, missing, dbg_state
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, done,
        output busy, finished, class_idx, max_value, missing, dbg_state
    );

endinterface

// File: rtl/rise_detect.sv
// Rising-edge detector: one flop of history, rise is high for the first cycle sig is seen high.
module rise_detect (
    input  logic clk,
    input  logic reset,
    input  logic sig,
    output logic rise
);

    logic prev_q;
    logic prev_d;

    always_comb begin
        prev_d = sig;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            prev_q <= 1'b0;
        end else begin
            prev_q <= prev_d;
        end
    end

    assign rise = sig & ~prev_q;

endmodule

// File: rtl/output_argmax.sv
// Captures the final layer's outputs into a slot bank, then on done's rising edge
// scans the slots one per cycle and reports the index and value of the largest.
module output_argmax
    import mlp_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    output_argmax_if.slave   bus
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = OUT_BASE_ADDR + ADDR_W'(NUM_OUT - 1);
    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(NUM_OUT - 1);

    argmax_state_t       state_q, state_d;
    logic [DATA_W-1:0]   slot_q [NUM_OUT];
    logic [DATA_W-1:0]   slot_d [NUM_OUT];
    logic [NUM_OUT-1:0]  written_q, written_d;
    logic [DATA_W-1:0]   best_q, best_d;
    logic [IDX_W-1:0]    best_idx_q, best_idx_d;
    logic [IDX_W-1:0]    i_q, i_d;
    logic                busy_q, busy_d;
    logic                finished_q, finished_d;
    logic [IDX_W-1:0]    class_idx_q, class_idx_d;
    logic [DATA_W-1:0]   max_value_q, max_value_d;
    logic                missing_q, missing_d;

    logic                start;
    logic                in_range;
    logic [IDX_W-1:0]    wr_idx;
    logic [DATA_W-1:0]   cand_val;
    logic [IDX_W-1:0]    cand_idx;

    rise_detect u_done_rise (
        .clk   (clk),
        .reset (reset),
        .sig   (bus.done),
        .rise  (start)
    );

    assign in_range = (bus.wr_addr >= OUT_BASE_ADDR) && (bus.wr_addr <= LAST_ADDR);
    assign wr_idx   = IDX_W'(bus.wr_addr - OUT_BASE_ADDR);

    // Strict greater-than so that ties keep the earlier (lower) index.
    always_comb begin
        if ($signed(slot_q[i_q]) > $signed(best_q)) begin
            cand_val = slot_q[i_q];
            cand_idx = i_q;
        end else begin
            cand_val = best_q;
            cand_idx = best_idx_q;
        end
    end

    always_comb begin
        state_d     = state_q;
        slot_d      = slot_q;
        written_d   = written_q;
        best_d      = best_q;
        best_idx_d  = best_idx_q;
        i_d         = i_q;
        busy_d      = busy_q;
        finished_d  = 1'b0;
        class_idx_d = class_idx_q;
        max_value_d = max_value_q;
        missing_d   = missing_q;

        case (state_q)
            IDLE: begin
                if (bus.wr_en && in_range) begin
                    slot_d[wr_idx]    = bus.wr_data;
                    written_d[wr_idx] = 1'b1;
                end
                // slot_q[0] is the registered value, so a same-cycle write to slot 0 is not seen here.
                if (start) begin
                    best_d     = slot_q[0];
                    best_idx_d = '0;
                    i_d        = IDX_W'(1);
                    busy_d     = 1'b1;
                    state_d    = SCAN;
                end
            end
            SCAN: begin
                best_d     = cand_val;
                best_idx_d = cand_idx;
                i_d        = i_q + IDX_W'(1);
                if (i_q == LAST_IDX) begin
                    class_idx_d = cand_idx;
                    max_value_d = cand_val;
                    finished_d  = 1'b1;
                    missing_d   = ~&written_q;
                    written_d   = '0;
                    busy_d      = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            for (int k = 0; k < NUM_OUT; k++) begin
                slot_q[k] <= '0;
            end
            written_q   <= '0;
            best_q      <= '0;
            best_idx_q  <= '0;
            i_q         <= '0;
            busy_q      <= 1'b0;
            finished_q  <= 1'b0;
            class_idx_q <= '0;
            max_value_q <= '0;
            missing_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            slot_q      <= slot_d;
            written_q   <= written_d;
            best_q      <= best_d;
            best_idx_q  <= best_idx_d;
            i_q         <= i_d;
            busy_q      <= busy_d;
            finished_q  <= finished_d;
            class_idx_q <= class_idx_d;
            max_value_q <= max_value_d;
            missing_q   <= missing_d;
        end
    end

    assign bus.busy      = busy_q;
    assign bus.finished  = finished_q;
    assign bus.class_idx = class_idx_q;
    assign bus.max_value = max_value_q;
    assign bus.missing   = missing_q;
    assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_output_argmax.sv
// Directed bench for output_argmax: table of full inferences plus hand-written
// sequences for ignored writes, held done, mid-scan reset and back-to-back runs.
module tb_output_argmax;
    import mlp_pkg::*;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    output_argmax_if bus ();

    output_argmax dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [NUM_OUT*DATA_W-1:0] vals;
        logic [NUM_OUT-1:0]        mask;
        logic [IDX_W-1:0]          exp_idx;
        logic [DATA_W-1:0]         exp_val;
        logic                      exp_missing;
    } vec_t;

    vec_t vecs [4];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [NUM_OUT*DATA_W-1:0] pk(input int a0, input int a1, input int a2,
        input int a3, input int a4, input int a5, input int a6, input int a7, input int a8, input int a9);
        pk = {16'(a9), 16'(a8), 16'(a7), 16'(a6), 16'(a5), 16'(a4), 16'(a3), 16'(a2), 16'(a1), 16'(a0)};
    endfunction

    task automatic write_slot(input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] data);
        bus.wr_en   = 1'b1;
        bus.wr_addr = addr;
        bus.wr_data = data;
        tick();
        bus.wr_en   = 1'b0;
    endtask

    task automatic write_all(input logic [NUM_OUT*DATA_W-1:0] vals, input logic [NUM_OUT-1:0] mask);
        for (int k = 0; k < NUM_OUT; k++) begin
            if (mask[k]) write_slot(OUT_BASE_ADDR + ADDR_W'(k), vals[k*DATA_W +: DATA_W]);
        end
    endtask

    // Waits for finished after the start edge; checks latency, pulse width and the result.
    task automatic wait_result(input string tag, input logic [IDX_W-1:0] exp_idx,
        input logic [DATA_W-1:0] exp_val, input logic exp_missing);
        int lat;
        lat = -1;
        for (int c = 1; c <= 40; c++) begin
            tick();
            if (bus.finished) begin
                lat = c;
                break;
            end
        end
        check({tag, " latency"}, 32'(lat), 32'd9);
        check({tag, " class_idx"}, 32'(bus.class_idx), 32'(exp_idx));
        check({tag, " max_value"}, 32'(bus.max_value), 32'(exp_val));
        check({tag, " missing"}, 32'(bus.missing), 32'(exp_missing));
        tick();
        check({tag, " pulse_width"}, 32'(bus.finished), 32'd0);
        check({tag, " busy_after"}, 32'(bus.busy), 32'd0);
        check({tag, " result_hold"}, 32'(bus.class_idx), 32'(exp_idx));
    endtask

    task automatic run_inference(input string tag, input logic [NUM_OUT*DATA_W-1:0] vals,
        input logic [NUM_OUT-1:0] mask, input logic [IDX_W-1:0] exp_idx,
        input logic [DATA_W-1:0] exp_val, input logic exp_missing);
        write_all(vals, mask);
        bus.done = 1'b1;
        tick();
        bus.done = 1'b0;
        check({tag, " busy_scan"}, 32'(bus.busy), 32'd1);
        wait_result(tag, exp_idx, exp_val, exp_missing);
    endtask

    initial begin
        int pulses;
        checks      = 0;
        errors      = 0;
        reset       = 1'b1;
        bus.wr_en   = 1'b0;
        bus.wr_addr = '0;
        bus.wr_data = '0;
        bus.done    = 1'b0;

        vecs[0] = '{pk(-1, -2, -3, -4, -5, -6, -7, -8, -9, 0), 10'h1FF, 4'd9, 16'h0000, 1'b1};
        vecs[1] = '{pk(5, 12, -3, 40, 7, 0, 39, -100, 1, 2), 10'h3FF, 4'd3, 16'd40, 1'b0};
        vecs[2] = '{pk(-5, -5, -5, -5, -5, -5, -5, -5, -5, -5), 10'h3FF, 4'd0, 16'hFFFB, 1'b0};
        vecs[3] = '{pk(-32768, -32768, -32768, -32768, -32768, -32768, -32768, -32768, -32768, 32767),
                    10'h3FF, 4'd9, 16'h7FFF, 1'b0};

        repeat (3) tick();
        reset = 1'b0;
        check("rst finished", 32'(bus.finished), 32'd0);
        check("rst busy", 32'(bus.busy), 32'd0);
        check("rst class_idx", 32'(bus.class_idx), 32'd0);
        check("rst max_value", 32'(bus.max_value), 32'd0);
        check("rst missing", 32'(bus.missing), 32'd0);
        check("rst state", 32'(bus.dbg_state), 32'(IDLE));

        // vecs[0] relies on slot 9 still holding its post-reset zero.
        for (int v = 0; v < 4; v++) begin
            run_inference($sformatf("vec%0d", v), vecs[v].vals, vecs[v].mask,
                vecs[v].exp_idx, vecs[v].exp_val, vecs[v].exp_missing);
        end

        // Out-of-range writes, rewrite, write during scan, done held high for 20 cycles.
        write_all(vecs[1].vals, 10'h3FF);
        write_slot(12'hC0A, 16'h7FFF);
        write_slot(12'hBFF, 16'h7FFF);
        write_slot(12'hC01, 16'd99);
        write_slot(12'hC01, 16'd12);
        bus.done = 1'b1;
        pulses   = 0;
        for (int c = 0; c < 20; c++) begin
            if (c == 2) begin
                check("ign busy_at_write", 32'(bus.busy), 32'd1);
                bus.wr_en   = 1'b1;
                bus.wr_addr = 12'hC05;
                bus.wr_data = 16'd100;
            end else begin
                bus.wr_en = 1'b0;
            end
            tick();
            if (bus.finished) pulses++;
        end
        bus.wr_en = 1'b0;
        bus.done  = 1'b0;
        check("held pulses", 32'(pulses), 32'd1);
        check("ign class_idx", 32'(bus.class_idx), 32'd3);
        check("ign max_value", 32'(bus.max_value), 32'd40);
        check("ign missing", 32'(bus.missing), 32'd0);
        // Only C05 written now; if the scan-time write had landed it would not be unwritten.
        run_inference("ign_after", pk(0, 0, 0, 0, 0, -50, 0, 0, 0, 0), 10'h020, 4'd3, 16'd40, 1'b1);

        // Reset four cycles after start aborts the scan with no pulse.
        write_all(vecs[1].vals, 10'h3FF);
        bus.done = 1'b1;
        tick();
        bus.done = 1'b0;
        repeat (3) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("abort finished", 32'(bus.finished), 32'd0);
        check("abort busy", 32'(bus.busy), 32'd0);
        check("abort class_idx", 32'(bus.class_idx), 32'd0);
        check("abort max_value", 32'(bus.max_value), 32'd0);
        check("abort missing", 32'(bus.missing), 32'd0);
        pulses = 0;
        for (int c = 0; c < 15; c++) begin
            tick();
            if (bus.finished) pulses++;
        end
        check("abort pulses", 32'(pulses), 32'd0);
        run_inference("post_abort", pk(-7, -7, -7, -7, -7, -7, 3, -7, -7, -7), 10'h3FF, 4'd6, 16'd3, 1'b0);

        // Back-to-back inferences with different winners.
        run_inference("b2b_a", pk(1, 1, 500, 1, 1, 1, 1, 1, 1, 1), 10'h3FF, 4'd2, 16'd500, 1'b0);
        run_inference("b2b_b", pk(1, 1, -1, 1, 1, 1, 1, 600, 1, 1), 10'h3FF, 4'd7, 16'd600, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/output_argmax.md
Name: output_argmax

Overview:
- Classifier stage directly downstream of the final MLP layer.
- Captures each output-neuron value as the layer writes it to its output address window (C00..C09).
- On the rising edge of the layer's done, scans the captured slots sequentially and reports the winning class index and its value with a one-cycle finished pulse.
- Replaces the single-value latch with a full 10-way argmax.

Parameters:
- NUM_OUT, 10: number of output neurons/classes; must be >= 2.
- DATA_W, 16: neuron output width, signed two's complement.
- ADDR_W, 12: write-address width.
- BASE_ADDR, 12'hC00: address of slot 0; slot k is at BASE_ADDR+k.
- IDX_W, 4: class index width; must satisfy 2^IDX_W >= NUM_OUT.

Ports:
- clk  in  1  clock.
- reset  in  1  reset, synchronous, active-high.
- wr_en  in  1  final-layer write strobe.
- wr_addr  in  ADDR_W  final-layer write address.
- wr_data  in  DATA_W  neuron output value, signed.
- done  in  1  final layer complete; level signal, edge-detected internally.
- busy  out  1  high while scanning.
- finished  out  1  one-cycle pulse: result valid.
- class_idx  out  IDX_W  index of the maximum slot.
- max_value  out  DATA_W  value of the maximum slot.
- missing  out  1  at least one slot was not written since the previous report.

Behaviour:
- Reset values:
  - finished=0, busy=0, class_idx=0, max_value=0, missing=0.
  - All slots=0, all written flags=0, prev_done=0, state=IDLE.
- Capture:
  - Applies when wr_en=1, state=IDLE and BASE_ADDR <= wr_addr <= BASE_ADDR+NUM_OUT-1.
  - Action: slot[wr_addr-BASE_ADDR] <= wr_data and that slot's written flag is set.
  - Out-of-range addresses are ignored.
  - A rewrite of the same slot overwrites it; last write wins.
- Edge detect: prev_done <= done every cycle (cleared by reset). start = done & ~prev_done.
- State IDLE:
  - On start: best <= slot[0], best_idx <= 0, i <= 1, go to SCAN, busy <= 1.
  - A write in the same cycle as start is captured, but is not visible to the slot[0] load if it targets slot 0 (the registered value is used).
- State SCAN:
  - Each cycle: if $signed(slot[i]) > $signed(best), then best <= slot[i] and best_idx <= i.
  - Strict greater-than, so ties keep the lowest index. Then i <= i+1.
  - When i == NUM_OUT-1, in the same edge:
    - class_idx <= final best_idx, max_value <= final best.
    - finished <= 1, missing <= ~&written.
    - All written flags cleared, busy <= 0, go to IDLE.
- Latency: finished is high in the cycle following edge E0+(NUM_OUT-1), where E0 is the edge that samples start. For NUM_OUT=10, finished rises 9 clocks after E0.
- Throughput: one inference per NUM_OUT cycles plus the write phase.
- finished is high for exactly one cycle. class_idx, max_value and missing hold until the next report or reset.
- During SCAN:
  - wr_en is ignored (slot values are frozen).
  - done edges are ignored; prev_done still tracks done, so a done held high across the scan does not retrigger.
- Unwritten slots take part in the scan with their current content: 0 after reset, otherwise the value from the prior inference. The missing flag reports this case.
- Reset mid-scan aborts with no finished pulse. Slots and flags are cleared.
- Arithmetic: signed compare only, no saturation, no width growth.

Decomposition:
- Shared package mlp_pkg holds:
  - constants NUM_OUT, DATA_W, OUT_BASE_ADDR=12'hC00, IDX_W;
  - state encoding typedef argmax_state_t {IDLE, SCAN}.
- One sub-module is natural: rise_detect (a single flop plus AND, producing start), reusable by other done consumers.
- The slot bank and comparator stay inline.

Test Plan:
- Write C00..C09 = 5,12,-3,40,7,0,39,-100,1,2, then a done 0->1 edge -> finished after 9 cycles with class_idx=3, max_value=40, missing=0, and a one-cycle pulse.
- All slots = -5 (16'hFFFB) -> class_idx=0, max_value=-5 (tie keeps the lowest index). Separately, slot9 = 16'h7FFF and the others = 16'h8000 -> class_idx=9, max_value=16'h7FFF.
- Write only C00..C08 (slot9 unwritten after reset = 0, others negative) -> class_idx=9, max_value=0, missing=1. The next fully written inference reports missing=0.
- Write to C0A and BFF with 16'h7FFF, and write C05 = 100 during SCAN (busy=1) -> all three writes are ignored and the result is unchanged. Holding done high for 20 cycles produces exactly one finished pulse.
- Assert reset 4 cycles after start -> no finished pulse, outputs=0, busy=0. A subsequent write plus done edge produces a correct result.
- Two back-to-back inferences with different data -> the second result reflects only the new writes, and finished pulses once per done edge.
